// File: rtl/ksz_bus_pkg.sv
// Shared types and constants for the KSZ host-bus master.
package ksz_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_AREC    = 3'd2,
    ST_DSETUP  = 3'd3,
    ST_DSTROBE = 3'd4,
    ST_DREC    = 3'd5
  } state_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_LO = 4'b0011;
  localparam logic [3:0] BE_HI = 4'b1100;

  localparam int ADDR_OFS_LSB = 0;
  localparam int ADDR_OFS_MSB = 7;
  localparam int ADDR_BE_LSB  = 12;
  localparam int ADDR_BE_MSB  = 15;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ksz_addr_encode.sv
// Builds the 16-bit address-phase word from offset/size and flags misaligned words.
module ksz_addr_encode
  import ksz_bus_pkg::*;
(
  input  logic [7:0]  i_offset,
  input  logic        i_word,
  output logic [15:0] o_addr,
  output logic        o_misaligned
);

  logic [3:0] w_be;

  always_comb begin
    w_be = BE_B0;
    if (i_word) begin
      w_be = i_offset[1] ? BE_HI : BE_LO;
    end else begin
      case (i_offset[1:0])
        2'd0:    w_be = BE_B0;
        2'd1:    w_be = BE_B1;
        2'd2:    w_be = BE_B2;
        default: w_be = BE_B3;
      endcase
    end
  end

  always_comb begin
    o_addr = '0;
    o_addr[ADDR_OFS_MSB:ADDR_OFS_LSB] = i_offset;
    o_addr[ADDR_BE_MSB:ADDR_BE_LSB]   = w_be;
  end

  assign o_misaligned = i_word & i_offset[0];

endmodule

// File: rtl/ksz_bus_master.sv
// KSZ register/QMU host-bus master: address phase, strobed data beats, bursts.
module ksz_bus_master
  import ksz_bus_pkg::*;
#(
  parameter int ADDR_CYC   = 2,
  parameter int STROBE_CYC = 2,
  parameter int RECOV_CYC  = 1,
  parameter int LEN_W      = 8
) (
  input  logic             clk40m,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [7:0]       cmd_offset,
  input  logic             cmd_word,
  input  logic             cmd_burst,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [15:0]      wdata,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [15:0]      rdata,
  output logic             rd_valid,
  output logic             err,
  output logic             busy,
  output logic             CMD,
  output logic             RDN,
  output logic             WRN,
  output logic [15:0]      sd_out,
  output logic             sd_oe,
  input  logic [15:0]      sd_in,
  output logic [2:0]       state
);

  localparam int CNT_MAX = max3(ADDR_CYC, STROBE_CYC, RECOV_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LD_ADDR   = CNT_W'(ADDR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RECOV  = CNT_W'(RECOV_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0] r_beats;
  logic             r_wr, w_wr_nxt;
  logic             r_cmd, r_rdn, r_wrn, r_oe, w_oe_nxt;
  logic             r_rd_valid, r_err;
  logic [15:0]      r_sd_out, r_rdata, w_addr;
  logic             w_accept, w_go, w_misaligned, w_done, w_wr_fire, w_rd_last;

  ksz_addr_encode u_addr (
    .i_offset     (cmd_offset),
    .i_word       (cmd_word),
    .o_addr       (w_addr),
    .o_misaligned (w_misaligned)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_go      = w_accept & ~w_misaligned;
  assign w_wr_nxt  = w_accept ? cmd_wr : r_wr;
  assign w_done    = (r_cnt == '0);
  assign w_wr_fire = (r_state == ST_DSETUP) & r_wr & wr_valid;
  assign w_rd_last = (r_state == ST_DSTROBE) & w_done & ~r_wr;

  // Reads have nothing to set up, so they go straight to the strobe.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_go) w_state_nxt = !cmd_burst ? ST_ADDR :
                                          (cmd_wr ? ST_DSETUP : ST_DSTROBE);
      ST_ADDR:    if (w_done) w_state_nxt = ST_AREC;
      ST_AREC:    if (w_done) w_state_nxt = r_wr ? ST_DSETUP : ST_DSTROBE;
      ST_DSETUP:  if (!r_wr || wr_valid) w_state_nxt = ST_DSTROBE;
      ST_DSTROBE: if (w_done) w_state_nxt = ST_DREC;
      ST_DREC:    if (w_done) w_state_nxt = (r_beats == '0) ? ST_IDLE :
                                            (r_wr ? ST_DSETUP : ST_DSTROBE);
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = w_done ? r_cnt : r_cnt - 1'b1;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_ADDR:          w_cnt_nxt = LD_ADDR;
        ST_AREC, ST_DREC: w_cnt_nxt = LD_RECOV;
        ST_DSTROBE:       w_cnt_nxt = LD_STROBE;
        default:          w_cnt_nxt = '0;
      endcase
    end
  end

  // Bus stays driven across write beats; reads release it before RDN can fall.
  always_comb begin
    w_oe_nxt = 1'b0;
    case (w_state_nxt)
      ST_ADDR:                     w_oe_nxt = 1'b1;
      ST_AREC, ST_DSTROBE, ST_DREC: w_oe_nxt = w_wr_nxt;
      ST_DSETUP:                   w_oe_nxt = r_oe;
      default:                     w_oe_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk40m) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_beats    <= '0;
      r_wr       <= 1'b0;
      r_cmd      <= 1'b1;
      r_rdn      <= 1'b1;
      r_wrn      <= 1'b1;
      r_oe       <= 1'b0;
      r_sd_out   <= '0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wr       <= w_wr_nxt;
      r_cmd      <= (w_state_nxt inside {ST_IDLE, ST_ADDR, ST_AREC});
      r_rdn      <= ~((w_state_nxt == ST_DSTROBE) & ~w_wr_nxt);
      r_wrn      <= ~((w_state_nxt == ST_ADDR) | ((w_state_nxt == ST_DSTROBE) & w_wr_nxt));
      r_oe       <= w_oe_nxt;
      r_rd_valid <= w_rd_last;
      r_err      <= w_accept & w_misaligned;
      if (w_go) begin
        r_beats <= cmd_burst ? cmd_len : '0;
        if (!cmd_burst) r_sd_out <= w_addr;
      end else if ((r_state == ST_DREC) && w_done && (r_beats != '0)) begin
        r_beats <= r_beats - 1'b1;
      end
      if (w_wr_fire) r_sd_out <= wdata;
      if (w_rd_last) r_rdata <= sd_in;
    end
  end

  assign wr_ready = w_wr_fire;
  assign rdata    = r_rdata;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;
  assign busy     = (r_state != ST_IDLE);
  assign CMD      = r_cmd;
  assign RDN      = r_rdn;
  assign WRN      = r_wrn;
  assign sd_out   = r_sd_out;
  assign sd_oe    = r_oe;
  assign state    = r_state;

endmodule

// File: tb/tb_ksz_bus_master.sv
// Directed bench for ksz_bus_master: single accesses, reject, bursts, mid-burst reset.
module tb_ksz_bus_master;

  logic        clk40m = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0, cmd_word = 1'b0, cmd_burst = 1'b0;
  logic [7:0]  cmd_offset = '0, cmd_len = '0;
  logic [15:0] wdata = '0, sd_in = '0;
  logic        wr_valid = 1'b0;
  logic        cmd_ready, wr_ready, rd_valid, err, busy, CMD, RDN, WRN, sd_oe;
  logic [15:0] rdata, sd_out;
  logic [2:0]  state;
  logic [6:0]  sig;

  ksz_bus_master dut (
    .clk40m(clk40m), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_offset(cmd_offset), .cmd_word(cmd_word), .cmd_burst(cmd_burst),
    .cmd_len(cmd_len), .wdata(wdata), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rdata(rdata), .rd_valid(rd_valid), .err(err), .busy(busy), .CMD(CMD), .RDN(RDN),
    .WRN(WRN), .sd_out(sd_out), .sd_oe(sd_oe), .sd_in(sd_in), .state(state)
  );

  always #5 clk40m = ~clk40m;

  assign sig = {CMD, RDN, WRN, sd_oe, rd_valid, cmd_ready, wr_ready};

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk40m);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] ofs, input logic wd,
                       input logic bu, input logic [7:0] len);
    cmd_wr = wr; cmd_offset = ofs; cmd_word = wd; cmd_burst = bu; cmd_len = len;
    cmd_valid = 1'b1;
    step;
    cmd_valid = 1'b0;
  endtask

  always @(negedge clk40m) begin
    if (!reset) begin
      chk("inv_oe_while_rdn", {31'd0, ~RDN & sd_oe}, 32'd0);
      chk("inv_both_strobes", {31'd0, ~RDN & ~WRN}, 32'd0);
    end
  end

  // {CMD,RDN,WRN,sd_oe,rd_valid,cmd_ready,wr_ready} per cycle after acceptance
  logic [6:0] rd_seq [7] = '{7'b1101000, 7'b1101000, 7'b1110000, 7'b0010000,
                             7'b0010000, 7'b0110100, 7'b1110010};
  logic [6:0] wr_seq [8] = '{7'b1101000, 7'b1101000, 7'b1111000, 7'b0111001,
                             7'b0101000, 7'b0101000, 7'b0111000, 7'b1110010};

  initial begin
    int nwr, nfall, stall, nrv, nlow;
    bit done, cmd_hi, saw_addr, hit;
    logic prev_wrn;

    step; step;
    chk("rst_CMD", CMD, 1); chk("rst_RDN", RDN, 1); chk("rst_WRN", WRN, 1);
    chk("rst_sd_oe", sd_oe, 0); chk("rst_sd_out", sd_out, 0); chk("rst_rdata", rdata, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 0); chk("rst_state", state, 0);
    reset = 1'b0;
    step;

    // word read 0x10
    sd_in = 16'hBEEF;
    issue(1'b0, 8'h10, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rd_sig_%0d", i), sig, rd_seq[i]);
      if (i == 0) chk("rd_addr", sd_out, 16'h3010);
      if (i == 5) chk("rd_rdata", rdata, 16'hBEEF);
      step;
    end

    // byte write 0x27
    wdata = 16'h00AB; wr_valid = 1'b1;
    issue(1'b1, 8'h27, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr_sig_%0d", i), sig, wr_seq[i]);
      if (i == 0) chk("wr_addr", sd_out, 16'h8027);
      if (i == 3) chk("wr_setup_state", state, 3);
      if (i == 4) chk("wr_data", sd_out, 16'h00AB);
      step;
    end

    // word write 0x12
    wdata = 16'h1234;
    issue(1'b1, 8'h12, 1'b1, 1'b0, 8'd0);
    chk("ww_addr", sd_out, 16'hC012);
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (state == 3'd0) done = 1; else step;
    end
    chk("ww_done", done, 1);
    wr_valid = 1'b0;
    step;

    // misaligned word read 0x11
    issue(1'b0, 8'h11, 1'b1, 1'b0, 8'd0);
    chk("mis_err", err, 1); chk("mis_ready", cmd_ready, 1);
    chk("mis_bus", {CMD, RDN, WRN, sd_oe}, 4'b1110); chk("mis_state", state, 0);
    step;
    chk("mis_err_pulse", err, 0); chk("mis_bus2", {CMD, RDN, WRN, sd_oe}, 4'b1110);

    // burst write, 4 beats, 3-cycle wr_valid gap before the third beat
    wr_valid = 1'b1; wdata = 16'h1000;
    issue(1'b1, 8'h00, 1'b1, 1'b1, 8'd3);
    nwr = 0; nfall = 0; stall = 0; done = 0; cmd_hi = 0; saw_addr = 0; prev_wrn = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      if (state == 3'd3 && nwr == 2 && stall < 3) begin wr_valid = 1'b0; stall++; end
      else wr_valid = 1'b1;
      wdata = 16'h1000 + 16'(nwr);
      #1;
      if (wr_ready) nwr++;
      if (!WRN && prev_wrn) begin
        chk($sformatf("bw_data_%0d", nfall), sd_out, 16'h1000 + 16'(nfall));
        nfall++;
      end
      prev_wrn = WRN;
      if (busy && CMD) cmd_hi = 1;
      if (state == 3'd1) saw_addr = 1;
      if (state == 3'd0) done = 1; else step;
    end
    wr_valid = 1'b0;
    chk("bw_done", done, 1); chk("bw_wrn_pulses", nfall, 4); chk("bw_wr_ready", nwr, 4);
    chk("bw_stall", stall, 3); chk("bw_cmd_low", cmd_hi, 0); chk("bw_no_addr", saw_addr, 0);
    step;

    // burst read, 8 beats
    sd_in = 16'hA000;
    issue(1'b0, 8'h00, 1'b1, 1'b1, 8'd7);
    chk("br_first_state", state, 4); chk("br_first_bus", {CMD, RDN, sd_oe}, 3'b000);
    nrv = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      sd_in = 16'hA000 + 16'(nrv);
      #1;
      if (rd_valid) begin
        chk($sformatf("br_rdata_%0d", nrv), rdata, 16'hA000 + 16'(nrv));
        nrv++;
      end
      if (state == 3'd0) done = 1; else step;
    end
    chk("br_done", done, 1); chk("br_beats", nrv, 8);
    step;

    // burst read interrupted by reset during beat 5
    issue(1'b0, 8'h00, 1'b1, 1'b1, 8'd7);
    nrv = 0; hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      sd_in = 16'hA000 + 16'(nrv);
      #1;
      if (rd_valid) nrv++;
      if (state == 3'd4 && nrv == 5) hit = 1; else step;
    end
    chk("rr_reached_beat5", hit, 1);
    reset = 1'b1;
    step;
    chk("rr_bus", {CMD, RDN, WRN, sd_oe}, 4'b1110); chk("rr_state", state, 0);
    chk("rr_rd_valid", rd_valid, 0);
    reset = 1'b0;
    nrv = 0; nlow = 0;
    for (int c = 0; c < 10; c++) begin
      step;
      if (rd_valid) nrv++;
      if (!RDN || !WRN) nlow++;
    end
    chk("rr_no_rd_valid", nrv, 0); chk("rr_no_strobe", nlow, 0);
    chk("rr_ready", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
